// File: rtl/bin_to_gray_if.sv
// ============================================================================
// Module      : bin_to_gray_if
// Description : Gray-word request / decoded-binary response bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bin_to_gray_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] gray;
    logic             in_valid;
    logic [WIDTH-1:0] bin;
    logic             out_valid;

    modport master (
        output gray,
        output in_valid,
        input  bin,
        input  out_valid
    );

    modport slave (
        input  gray,
        input  in_valid,
        output bin,
        output out_valid
    );
endinterface

`default_nettype wire

// File: rtl/bin_to_gray.sv
// ============================================================================
// Module      : bin_to_gray
// Description : Registered Gray-to-binary decoder, LATENCY-deep pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_to_gray #(
    parameter int WIDTH   = 4,
    parameter int LATENCY = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    bin_to_gray_if.slave  bus
);

    logic [WIDTH-1:0] w_bin;
    logic [WIDTH-1:0] r_bin [LATENCY];
    logic [LATENCY-1:0] r_vld;

    // Each output bit is the parity of all Gray bits at or above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
        assign w_bin[i] = ^bus.gray[WIDTH-1:i];
    end

    // Data registers only load behind a valid bit, so the output holds its
    // last decoded word while the valid bit carries bubbles downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < LATENCY; s++) begin
                r_bin[s] <= '0;
            end
            r_vld <= '0;
        end else begin
            r_vld[0] <= bus.in_valid;
            if (bus.in_valid) begin
                r_bin[0] <= w_bin;
            end
            for (int s = 1; s < LATENCY; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) begin
                    r_bin[s] <= r_bin[s-1];
                end
            end
        end
    end

    assign bus.bin       = r_bin[LATENCY-1];
    assign bus.out_valid = r_vld[LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_bin_to_gray.sv
// ============================================================================
// Module      : tb_bin_to_gray
// Description : Self-checking bench for bin_to_gray across three configurations.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_to_gray;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic chk_en = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [2:0][31:0] tb_gray;
    logic [2:0]       tb_vld;
    logic [2:0][31:0] tb_bin;
    logic [2:0]       tb_ov;

    always #5 clk = ~clk;

    // Reference decode: binary = gray ^ (gray>>1) ^ (gray>>2) ^ ...
    function automatic logic [31:0] g2b(input logic [31:0] g, input int w);
        logic [31:0] b;
        logic [31:0] m;
        m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        g = g & m;
        b = '0;
        for (int k = 0; k < w; k++) b = b ^ (g >> k);
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // d0: WIDTH 4 LATENCY 1, d1: WIDTH 4 LATENCY 3, d2: WIDTH 16 LATENCY 1
    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int W = (k == 2) ? 16 : 4;
        localparam int L = (k == 1) ? 3 : 1;

        bin_to_gray_if #(.WIDTH(W)) bus ();

        assign bus.gray     = tb_gray[k][W-1:0];
        assign bus.in_valid = tb_vld[k];
        assign tb_bin[k]    = 32'(bus.bin);
        assign tb_ov[k]     = bus.out_valid;

        bin_to_gray #(.WIDTH(W), .LATENCY(L)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus.slave)
        );

        logic [32:0] hist [$];
        logic [32:0] e;
        logic [31:0] held = '0;
        logic        ev   = 1'b0;

        // History of accepted inputs; the output shows the entry L-1 edges old.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                hist.delete();
                held = '0;
                ev   = 1'b0;
            end else begin
                hist.push_back({tb_vld[k], g2b(tb_gray[k], W)});
                ev = 1'b0;
                if (hist.size() >= L) begin
                    e  = hist[hist.size() - L];
                    ev = e[32];
                    if (e[32]) held = e[31:0];
                end
                while (hist.size() > L) void'(hist.pop_front());
            end
        end

        initial forever begin
            @(posedge clk);
            #2;
            if (chk_en) begin
                chk($sformatf("d%0d_out_valid", k), {31'd0, tb_ov[k]}, {31'd0, ev});
                chk($sformatf("d%0d_bin", k), tb_bin[k], held);
            end
        end
    end

    task automatic drive(input int k, input logic [31:0] g, input logic v);
        @(negedge clk);
        tb_gray[k] = g;
        tb_vld[k]  = v;
    endtask

    logic [3:0] sweep_exp [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h7, 4'h6, 4'h4, 4'h5,
                                   4'hF, 4'hE, 4'hC, 4'hD, 4'h8, 4'h9, 4'hB, 4'hA};

    initial begin
        bit seen;
        tb_gray = '0;
        tb_vld  = '0;

        // Asynchronous reset with live inputs
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            tb_gray[k] = $urandom;
            tb_vld[k]  = 1'b1;
        end
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_async_bin_d%0d", k), tb_bin[k], 32'd0);
            chk($sformatf("reset_async_valid_d%0d", k), {31'd0, tb_ov[k]}, 32'd0);
        end
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst    = 1'b0;
        tb_vld = '0;

        // Exhaustive 4-bit sweep on d0
        for (int g = 0; g < 16; g++) begin
            drive(0, 32'(g), 1'b1);
            @(posedge clk); #2;
            chk("sweep_bin", tb_bin[0], {28'd0, sweep_exp[g]});
            chk("sweep_valid", {31'd0, tb_ov[0]}, 32'd1);
        end

        // Hold while in_valid is low
        drive(0, 32'b0110, 1'b1);
        @(posedge clk); #2;
        chk("hold_first", tb_bin[0], 32'b0100);
        drive(0, 32'b1111, 1'b0);
        repeat (3) begin
            @(posedge clk); #2;
            chk("hold_bin", tb_bin[0], 32'b0100);
            chk("hold_valid", {31'd0, tb_ov[0]}, 32'd0);
        end
        drive(0, 32'b1111, 1'b1);
        @(posedge clk); #2;
        chk("hold_resume", tb_bin[0], 32'b1010);
        drive(0, 32'd0, 1'b0);

        // LATENCY 3 single pulse
        drive(1, 32'b1000, 1'b1);
        @(posedge clk); #2;
        chk("lat_early", {31'd0, tb_ov[1]}, 32'd0);
        @(negedge clk) tb_vld[1] = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #2;
            chk($sformatf("lat_valid_c%0d", c), {31'd0, tb_ov[1]}, (c == 2) ? 32'd1 : 32'd0);
            if (c == 2) chk("lat_bin", tb_bin[1], 32'b1111);
        end

        // Mid-stream reset discards in-flight words
        drive(1, 32'b1100, 1'b1);
        drive(1, 32'b1101, 1'b1);
        @(negedge clk);
        tb_vld[1] = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #2;
            chk("midrst_no_valid", {31'd0, tb_ov[1]}, 32'd0);
        end
        drive(1, 32'b0101, 1'b1);
        @(negedge clk) tb_vld[1] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            @(posedge clk); #2;
            if (tb_ov[1]) begin
                seen = 1'b1;
                chk("midrst_recover_bin", tb_bin[1], 32'b0110);
            end
        end
        if (!seen) chk("midrst_recover_timeout", 32'd0, 32'd1);

        // Random traffic on all three configurations
        repeat (200) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                tb_gray[k] = $urandom;
                tb_vld[k]  = ($urandom_range(3) != 0);
            end
        end

        // Wide all-ones corner
        drive(2, 32'h0000_FFFF, 1'b1);
        @(posedge clk); #2;
        chk("wide_all_ones", tb_bin[2], 32'h0000_AAAA);
        chk("wide_all_ones_valid", {31'd0, tb_ov[2]}, 32'd1);
        drive(2, 32'h0000_8000, 1'b1);
        @(posedge clk); #2;
        chk("wide_msb_only", tb_bin[2], 32'h0000_FFFF);

        @(negedge clk);
        tb_vld = '0;
        repeat (4) @(posedge clk);
        #3;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
